// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/operand/execute sequencer driving an external 8-bit ALU.
// Each instruction is an opcode byte plus an immediate/address byte; HLT has no operand byte.
module cpu_control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_y,
    input  logic       alu_z,
    output logic [7:0] acc,
    output logic       zf,
    output logic       instr_done,
    output logic       halted
);

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_OPERAND = 2'd1;
    localparam logic [1:0] S_EXEC    = 2'd2;
    localparam logic [1:0] S_HALT    = 2'd3;

    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    logic [1:0] r_state;
    logic [7:0] r_pc;
    logic [2:0] r_op;   // only ir[7:5] is ever observed, so the ignored low bits are not stored
    logic [7:0] r_opr;
    logic [7:0] r_acc;
    logic       r_zf;
    logic [7:0] w_pc_inc;

    assign w_pc_inc = r_pc + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_op    <= 3'b000;
            r_opr   <= 8'h00;
            r_acc   <= 8'h00;
            r_zf    <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_op    <= mem_data[7:5];
                    r_pc    <= w_pc_inc;
                    r_state <= (mem_data[7:5] == OP_HLT) ? S_HALT : S_OPERAND;
                end
                S_OPERAND: begin
                    r_opr   <= mem_data;
                    r_pc    <= w_pc_inc;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (r_op)
                        OP_JMP: r_pc <= r_opr;
                        OP_JZ: begin
                            if (r_zf) begin
                                r_pc <= r_opr;
                            end
                        end
                        OP_HLT: begin
                        end
                        default: begin
                            r_acc <= alu_y;
                            r_zf  <= alu_z;
                        end
                    endcase
                    r_state <= S_FETCH;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign mem_addr   = r_pc;
    assign alu_a      = r_acc;
    assign alu_b      = r_opr;
    assign alu_sel    = r_op;
    assign acc        = r_acc;
    assign zf         = r_zf;
    assign instr_done = (r_state == S_EXEC);
    assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: behavioural ROM and ALU around two instances
// (RESET_PC 00 and FE), program table with an instr_done scoreboard, plus reset/wrap sequences.
module tb_cpu_control_unit;

    logic clk;
    logic rst0, rst1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] rom0 [0:255];
    logic [7:0] rom1 [0:255];

    logic [7:0] mem_addr0, mem_data0, alu_a0, alu_b0, alu_y0, acc0;
    logic [2:0] alu_sel0;
    logic       alu_z0, zf0, done0, halted0;

    logic [7:0] mem_addr1, mem_data1, alu_a1, alu_b1, alu_y1, acc1;
    logic [2:0] alu_sel1;
    logic       alu_z1, zf1, done1, halted1;

    function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'd0:    return b;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            default: return 8'h00;
        endcase
    endfunction

    assign mem_data0 = rom0[mem_addr0];
    assign alu_y0    = alu_f(alu_sel0, alu_a0, alu_b0);
    assign alu_z0    = (alu_y0 == 8'h00);
    assign mem_data1 = rom1[mem_addr1];
    assign alu_y1    = alu_f(alu_sel1, alu_a1, alu_b1);
    assign alu_z1    = (alu_y1 == 8'h00);

    cpu_control_unit #(.RESET_PC(8'h00)) dut0 (
        .clk(clk), .rst(rst0), .mem_addr(mem_addr0), .mem_data(mem_data0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_sel(alu_sel0), .alu_y(alu_y0), .alu_z(alu_z0),
        .acc(acc0), .zf(zf0), .instr_done(done0), .halted(halted0)
    );

    cpu_control_unit #(.RESET_PC(8'hFE)) dut1 (
        .clk(clk), .rst(rst1), .mem_addr(mem_addr1), .mem_data(mem_data1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_y(alu_y1), .alu_z(alu_z1),
        .acc(acc1), .zf(zf1), .instr_done(done1), .halted(halted1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: one {acc, zf} entry per executed instruction, checked the cycle after EXEC.
    logic [8:0] sb_q[$];
    logic       sb_en   = 1'b0;
    logic       prev_done = 1'b0;

    always @(negedge clk) begin
        logic [8:0] e;
        if (sb_en && prev_done) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got extra instr_done expected none");
            end else begin
                e = sb_q.pop_front();
                chk("sb_acc", {24'd0, acc0}, {24'd0, e[8:1]});
                chk("sb_zf", {31'd0, zf0}, {31'd0, e[0]});
            end
        end
        prev_done = done0;
    end

    typedef struct packed {
        logic [127:0] rom;      // bytes right-aligned, first byte leftmost
        int           len;
        int           n_done;
        logic [63:0]  acc_seq;
        logic [7:0]   zf_seq;
        logic [7:0]   halt_pc;
        logic [7:0]   fin_acc;
        logic         fin_zf;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int cnt;
        for (int i = 0; i < 256; i++) rom0[i] = 8'hE0;
        for (int i = 0; i < v.len; i++) rom0[i] = v.rom[8*(v.len-1-i) +: 8];
        sb_q.delete();
        for (int i = 0; i < v.n_done; i++)
            sb_q.push_back({v.acc_seq[8*(v.n_done-1-i) +: 8], v.zf_seq[v.n_done-1-i]});
        sb_en = 1'b1;
        rst0  = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_rst_pc", idx), {24'd0, mem_addr0}, 32'h00);
        chk($sformatf("v%0d_rst_acc", idx), {24'd0, acc0}, 32'h00);
        chk($sformatf("v%0d_rst_ctl", idx), {28'd0, zf0, done0, halted0, 1'b0}, 32'h0);
        chk($sformatf("v%0d_rst_alu", idx), {13'd0, alu_sel0, alu_b0, alu_a0}, 32'h0);
        rst0 = 1'b0;
        cnt  = 0;
        while (!halted0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk($sformatf("v%0d_halted", idx), {31'd0, halted0}, 32'h1);
        chk($sformatf("v%0d_halt_pc", idx), {24'd0, mem_addr0}, {24'd0, v.halt_pc});
        chk($sformatf("v%0d_halt_acc", idx), {24'd0, acc0}, {24'd0, v.fin_acc});
        chk($sformatf("v%0d_halt_zf", idx), {31'd0, zf0}, {31'd0, v.fin_zf});
        repeat (20) @(negedge clk);
        chk($sformatf("v%0d_sb_left", idx), sb_q.size(), 32'd0);
        chk($sformatf("v%0d_frozen", idx), {14'd0, done0, halted0, mem_addr0, acc0},
            {14'd0, 1'b0, 1'b1, v.halt_pc, v.fin_acc});
    endtask

    vec_t vecs[7];

    initial begin
        int cnt, ndone, last, gap_bad;
        rst0 = 1'b1;
        rst1 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            rom0[i] = 8'hE0;
            rom1[i] = 8'hE0;
        end

        vecs[0] = '{rom: {8'h00,8'h05,8'h20,8'h03,8'hE0}, len: 5, n_done: 2,
                    acc_seq: {8'h05,8'h08}, zf_seq: 8'b00, halt_pc: 8'h05, fin_acc: 8'h08, fin_zf: 1'b0};
        vecs[1] = '{rom: {8'h00,8'h03,8'h40,8'h03,8'hC0,8'h08,8'h00,8'hFF,8'hE0}, len: 9, n_done: 3,
                    acc_seq: {8'h03,8'h00,8'h00}, zf_seq: 8'b011, halt_pc: 8'h09, fin_acc: 8'h00, fin_zf: 1'b1};
        vecs[2] = '{rom: {8'h00,8'h01,8'hC0,8'h06,8'h00,8'hAA,8'hE0}, len: 7, n_done: 3,
                    acc_seq: {8'h01,8'h01,8'hAA}, zf_seq: 8'b000, halt_pc: 8'h07, fin_acc: 8'hAA, fin_zf: 1'b0};
        vecs[3] = '{rom: {8'h00,8'hF0,8'h60,8'h3C,8'h80,8'h01,8'hE0}, len: 7, n_done: 3,
                    acc_seq: {8'hF0,8'h30,8'h31}, zf_seq: 8'b000, halt_pc: 8'h07, fin_acc: 8'h31, fin_zf: 1'b0};
        vecs[4] = '{rom: {8'h00,8'hFF,8'h20,8'h01,8'hE0}, len: 5, n_done: 2,
                    acc_seq: {8'hFF,8'h00}, zf_seq: 8'b01, halt_pc: 8'h05, fin_acc: 8'h00, fin_zf: 1'b1};
        vecs[5] = '{rom: {8'h00,8'h07,8'hA0,8'h06,8'h00,8'h99,8'hE0}, len: 7, n_done: 2,
                    acc_seq: {8'h07,8'h07}, zf_seq: 8'b00, halt_pc: 8'h07, fin_acc: 8'h07, fin_zf: 1'b0};
        vecs[6] = '{rom: {8'h1F,8'h02,8'h40,8'h03,8'hF5}, len: 5, n_done: 2,
                    acc_seq: {8'h02,8'hFF}, zf_seq: 8'b00, halt_pc: 8'h05, fin_acc: 8'hFF, fin_zf: 1'b0};

        @(negedge clk);
        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Reset pulse during the EXEC of ADD must abort it with no partial update.
        sb_en = 1'b0;
        for (int i = 0; i < 256; i++) rom0[i] = 8'hE0;
        rom0[0] = 8'h00; rom0[1] = 8'h05; rom0[2] = 8'h20; rom0[3] = 8'h03;
        rst0 = 1'b1;
        @(negedge clk);
        rst0  = 1'b0;
        ndone = 0;
        cnt   = 0;
        while (ndone < 2 && cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (done0) ndone++;
        end
        chk("abort_reach_exec", ndone, 2);
        chk("abort_pre_acc", {24'd0, acc0}, 32'h05);
        rst0 = 1'b1;
        #1;
        chk("abort_async_acc", {24'd0, acc0}, 32'h00);
        chk("abort_async_pc", {24'd0, mem_addr0}, 32'h00);
        rst0 = 1'b0;
        @(negedge clk);
        chk("abort_after_acc", {24'd0, acc0}, 32'h00);
        chk("abort_restart", {23'd0, halted0, mem_addr0}, {23'd0, 1'b0, 8'h01});

        // pc wraps from FF to 00 while reading the operand byte.
        rom1[8'hFE] = 8'h00; rom1[8'hFF] = 8'h77; rom1[8'h00] = 8'hE0;
        @(negedge clk);
        chk("wrap_rst_pc", {24'd0, mem_addr1}, 32'hFE);
        rst1 = 1'b0;
        cnt  = 0;
        while (!halted1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("wrap_halted", {31'd0, halted1}, 32'h1);
        chk("wrap_acc", {24'd0, acc1}, 32'h77);
        chk("wrap_pc", {24'd0, mem_addr1}, 32'h01);

        // JMP FE at FE: tight loop, instr_done every third cycle.
        rom1[8'hFE] = 8'hA0; rom1[8'hFF] = 8'hFE;
        rst1 = 1'b1;
        @(negedge clk);
        rst1    = 1'b0;
        ndone   = 0;
        last    = -1;
        gap_bad = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (halted1) gap_bad++;
            if (done1) begin
                if (last >= 0 && c - last != 3) gap_bad++;
                last = c;
                ndone++;
            end
        end
        chk("jmp_loop_count", ndone, 10);
        chk("jmp_loop_gaps", gap_bad, 0);
        chk("jmp_loop_acc", {24'd0, acc1}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
